// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter shared by a video fetcher and a CPU.
// Video has priority. The CPU is forced ahead once it has lost CPU_MAX_WAIT
// consecutive cycles. The winner's access is registered onto mem_* at the
// arbitration edge, and its ack pulses in the following cycle. Read data
// returns two cycles after the ack, routed by a 2-stage tag pipeline.
// Optional feature: define MEM_ARBITER_STATS_EN to add the saturating
// stat_cpu_stall / stat_vid_grants counters.
module mem_arbiter #(
  parameter int unsigned CPU_MAX_WAIT = 4,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_rdata,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_valid,
`ifdef MEM_ARBITER_STATS_EN
  output logic [15:0]       stat_cpu_stall,
  output logic [15:0]       stat_vid_grants,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_VID  = 2'b01,
    ST_CPU  = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_VID  = 2'b01,
    TAG_CPU  = 2'b10
  } tag_t;

  localparam logic [3:0] C_MAX_WAIT = 4'(CPU_MAX_WAIT);

  // Grant state and arbitration
  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_cpu_wait;
  logic [3:0]        w_cpu_wait_nxt;
  logic              w_cpu_stall;
  logic              w_vid_grant;

  // Registered memory-side and ack outputs
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [7:0]        r_mem_wdata;
  logic              r_vid_ack;
  logic              r_cpu_ack;

  // Read-return tag pipeline and data registers
  tag_t              w_tag0;
  tag_t              r_tag1;
  logic [7:0]        r_vid_rdata;
  logic [7:0]        r_cpu_rdata;
  logic              r_vid_valid;
  logic              r_cpu_valid;

  // Choose this cycle's winner: video first, unless the CPU has waited its limit
  always_comb begin
    w_next_state = ST_IDLE;
    if (vid_req && cpu_req) begin
      if (r_cpu_wait == C_MAX_WAIT) begin
        w_next_state = ST_CPU;
      end else begin
        w_next_state = ST_VID;
      end
    end else if (vid_req) begin
      w_next_state = ST_VID;
    end else if (cpu_req) begin
      w_next_state = ST_CPU;
    end else begin
      w_next_state = ST_IDLE;
    end
  end

  // CPU starvation counter: counts losing cycles, saturates, clears on grant or idle
  always_comb begin
    w_cpu_stall    = cpu_req && (w_next_state != ST_CPU);
    w_vid_grant    = (w_next_state == ST_VID);
    w_cpu_wait_nxt = 4'd0;
    if (w_cpu_stall) begin
      if (r_cpu_wait < C_MAX_WAIT) begin
        w_cpu_wait_nxt = r_cpu_wait + 4'd1;
      end else begin
        w_cpu_wait_nxt = C_MAX_WAIT;
      end
    end else begin
      w_cpu_wait_nxt = 4'd0;
    end
  end

  // Grant FSM: register the winner's access onto the memory port and raise its ack
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cpu_wait  <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= 8'd0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cpu_wait <= w_cpu_wait_nxt;
      case (w_next_state)
        ST_VID: begin
          r_mem_addr <= vid_addr;
          r_mem_we   <= 1'b0;
          r_vid_ack  <= 1'b1;
          r_cpu_ack  <= 1'b0;
        end
        ST_CPU: begin
          r_mem_addr  <= cpu_addr;
          r_mem_we    <= cpu_we;
          r_mem_wdata <= cpu_wdata;
          r_vid_ack   <= 1'b0;
          r_cpu_ack   <= 1'b1;
        end
        default: begin
          // Idle: no strobe, address and write data keep their last values
          r_mem_we  <= 1'b0;
          r_vid_ack <= 1'b0;
          r_cpu_ack <= 1'b0;
        end
      endcase
    end
  end

  // First tag stage is decoded from the grant now on the memory port (writes return nothing)
  always_comb begin
    w_tag0 = TAG_NONE;
    case (r_state)
      ST_VID: w_tag0 = TAG_VID;
      ST_CPU: begin
        if (r_mem_we) begin
          w_tag0 = TAG_NONE;
        end else begin
          w_tag0 = TAG_CPU;
        end
      end
      default: w_tag0 = TAG_NONE;
    endcase
  end

  // Second tag stage: steer mem_rdata into the owning requester and pulse its valid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tag1      <= TAG_NONE;
      r_vid_rdata <= 8'd0;
      r_cpu_rdata <= 8'd0;
      r_vid_valid <= 1'b0;
      r_cpu_valid <= 1'b0;
    end else begin
      r_tag1      <= w_tag0;
      r_vid_valid <= 1'b0;
      r_cpu_valid <= 1'b0;
      case (r_tag1)
        TAG_VID: begin
          r_vid_rdata <= mem_rdata;
          r_vid_valid <= 1'b1;
        end
        TAG_CPU: begin
          r_cpu_rdata <= mem_rdata;
          r_cpu_valid <= 1'b1;
        end
        default: begin
          r_vid_rdata <= r_vid_rdata;
          r_cpu_rdata <= r_cpu_rdata;
        end
      endcase
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [15:0] r_stat_cpu_stall;
  logic [15:0] r_stat_vid_grants;

  // Saturating counters for CPU stall cycles and video grants
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_cpu_stall  <= 16'd0;
      r_stat_vid_grants <= 16'd0;
    end else begin
      if (w_cpu_stall && (r_stat_cpu_stall != 16'hFFFF)) begin
        r_stat_cpu_stall <= r_stat_cpu_stall + 16'd1;
      end else begin
        r_stat_cpu_stall <= r_stat_cpu_stall;
      end
      if (w_vid_grant && (r_stat_vid_grants != 16'hFFFF)) begin
        r_stat_vid_grants <= r_stat_vid_grants + 16'd1;
      end else begin
        r_stat_vid_grants <= r_stat_vid_grants;
      end
    end
  end

  assign stat_cpu_stall  = r_stat_cpu_stall;
  assign stat_vid_grants = r_stat_vid_grants;
`endif

  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign vid_ack   = r_vid_ack;
  assign cpu_ack   = r_cpu_ack;
  assign vid_rdata = r_vid_rdata;
  assign cpu_rdata = r_cpu_rdata;
  assign vid_valid = r_vid_valid;
  assign cpu_valid = r_cpu_valid;

endmodule
